// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational (0 cycles); training and flush take effect after one edge; no backpressure.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 30
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic            predict_taken,
  output logic [PC_W-1:0] target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  logic             wr_en_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [PC_W-1:0]  wr_tgt_d;
  logic [1:0]       wr_ctr_d;

  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W];
  assign u_idx  = upd_pc[IDX_W-1:0];
  assign u_tag  = upd_pc[PC_W-1:IDX_W];

  // Lookup reads stored state only, so a same-cycle update is never bypassed.
  always_comb begin
    hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken = hit && ctr_q[lk_idx][1];
    target        = hit ? tgt_q[lk_idx] : '0;
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    wr_en_d  = 1'b0;
    wr_tag_d = tag_q[u_idx];
    wr_tgt_d = tgt_q[u_idx];
    wr_ctr_d = ctr_q[u_idx];
    if (upd_en && !flush) begin
      if (u_hit) begin
        wr_en_d = 1'b1;
        if (upd_taken) begin
          wr_ctr_d = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
          wr_tgt_d = upd_target;
        end else begin
          wr_ctr_d = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate weakly taken, evicting whatever occupied this index.
        wr_en_d  = 1'b1;
        wr_tag_d = u_tag;
        wr_tgt_d = upd_target;
        wr_ctr_d = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_d) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= wr_tag_d;
      tgt_q[u_idx]   <= wr_tgt_d;
      ctr_q[u_idx]   <= wr_ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, counters, conflicts, flush, hazards, reset.
module tb_branch_target_buffer;

  localparam int PC_W = 30;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [PC_W-1:0] lookup_pc;
  logic            hit;
  logic            predict_taken;
  logic [PC_W-1:0] target;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            flush;

  int n_cmp = 0;
  int n_bad = 0;

  branch_target_buffer #(.ENTRIES(16), .PC_W(PC_W)) dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit),
    .predict_taken(predict_taken), .target(target), .upd_en(upd_en),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush)
  );

  always #5 CLK = ~CLK;

  // Drives one training update across one rising edge.
  task automatic drive_update(input logic [PC_W-1:0] pc, input logic tk,
                              input logic [PC_W-1:0] tg);
    @(negedge CLK);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    @(posedge CLK);
    #1 upd_en = 1'b0;
  endtask

  task automatic look(input logic [PC_W-1:0] pc);
    @(negedge CLK);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; flush = 1'b0; lookup_pc = '0;
    #3;
    n_cmp++;
    if ({hit, predict_taken, target} !== '0) begin
      n_bad++;
      $display("FAIL reset_during: got hit=%b pt=%b tgt=%h, want 0/0/0", hit, predict_taken, target);
    end
    @(negedge CLK); nRST = 1'b1;
    for (int i = 0; i < 16; i++) begin
      look(PC_W'(i));
      n_cmp++;
      if ({hit, predict_taken, target} !== '0) begin
        n_bad++;
        $display("FAIL reset_sweep pc=%0d: got hit=%b pt=%b tgt=%h, want 0/0/0", i, hit, predict_taken, target);
      end
    end
  endtask

  task automatic test_alloc;
    drive_update(30'h45, 1'b1, 30'h100);
    look(30'h45);
    n_cmp++;
    if ({hit, predict_taken, target} !== {1'b1, 1'b1, 30'h100}) begin
      n_bad++;
      $display("FAIL alloc_hit: got hit=%b pt=%b tgt=%h, want 1/1/100", hit, predict_taken, target);
    end
    look(30'h55);
    n_cmp++;
    if ({hit, predict_taken, target} !== '0) begin
      n_bad++;
      $display("FAIL alloc_tag_miss: got hit=%b pt=%b tgt=%h, want 0/0/0", hit, predict_taken, target);
    end
  endtask

  task automatic test_saturation;
    // ctr 2 -> 3,3,3: always predicts taken
    for (int i = 0; i < 3; i++) begin
      drive_update(30'h45, 1'b1, 30'h100);
      look(30'h45);
      n_cmp++;
      if ({hit, predict_taken, target} !== {1'b1, 1'b1, 30'h100}) begin
        n_bad++;
        $display("FAIL sat_up step %0d: got hit=%b pt=%b tgt=%h, want 1/1/100", i, hit, predict_taken, target);
      end
    end
    // ctr 3 -> 2,1,0,0 ; target must not change on not-taken
    for (int i = 0; i < 4; i++) begin
      drive_update(30'h45, 1'b0, 30'h3ff);
      look(30'h45);
      n_cmp++;
      if ({hit, predict_taken, target} !== {1'b1, (i == 0), 30'h100}) begin
        n_bad++;
        $display("FAIL sat_down step %0d: got hit=%b pt=%b tgt=%h, want 1/%0d/100", i, hit, predict_taken, target, (i == 0));
      end
    end
    // a wrapped counter (3) would predict taken after this; 0 -> 1 must not
    drive_update(30'h45, 1'b1, 30'h100);
    look(30'h45);
    n_cmp++;
    if ({hit, predict_taken} !== 2'b10) begin
      n_bad++;
      $display("FAIL sat_floor: got hit=%b pt=%b, want 1/0", hit, predict_taken);
    end
  endtask

  task automatic test_conflict;
    drive_update(30'h75, 1'b0, 30'h200);
    look(30'h45);
    n_cmp++;
    if ({hit, target} !== {1'b1, 30'h100}) begin
      n_bad++;
      $display("FAIL conflict_nt_kept: got hit=%b tgt=%h, want 1/100", hit, target);
    end
    drive_update(30'h75, 1'b1, 30'h200);
    look(30'h45);
    n_cmp++;
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL conflict_evicted: got hit=%b, want 0", hit);
    end
    look(30'h75);
    n_cmp++;
    if ({hit, predict_taken, target} !== {1'b1, 1'b1, 30'h200}) begin
      n_bad++;
      $display("FAIL conflict_alloc: got hit=%b pt=%b tgt=%h, want 1/1/200", hit, predict_taken, target);
    end
    // allocated at 2, so one not-taken lands at 1
    drive_update(30'h75, 1'b0, 30'h0);
    look(30'h75);
    n_cmp++;
    if ({hit, predict_taken} !== 2'b10) begin
      n_bad++;
      $display("FAIL conflict_ctr2: got hit=%b pt=%b, want 1/0", hit, predict_taken);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 16; i++) drive_update(PC_W'(i), 1'b1, PC_W'(12'h300 + i));
    look(30'h3);
    n_cmp++;
    if ({hit, target} !== {1'b1, 30'h303}) begin
      n_bad++;
      $display("FAIL fill_3: got hit=%b tgt=%h, want 1/303", hit, target);
    end
    look(30'hf);
    n_cmp++;
    if ({hit, target} !== {1'b1, 30'h30f}) begin
      n_bad++;
      $display("FAIL fill_15: got hit=%b tgt=%h, want 1/30f", hit, target);
    end
    @(negedge CLK);
    flush = 1'b1; upd_en = 1'b1; upd_pc = 30'h3; upd_taken = 1'b1; upd_target = 30'h123;
    @(posedge CLK);
    #1 flush = 1'b0; upd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      look(PC_W'(i));
      n_cmp++;
      if ({hit, predict_taken, target} !== '0) begin
        n_bad++;
        $display("FAIL flush pc=%0d: got hit=%b pt=%b tgt=%h, want 0/0/0", i, hit, predict_taken, target);
      end
    end
  endtask

  task automatic test_hazard_reset;
    @(negedge CLK);
    lookup_pc = 30'h12;
    upd_en = 1'b1; upd_pc = 30'h12; upd_taken = 1'b1; upd_target = 30'h40;
    #1;
    n_cmp++;
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL hazard_same_cycle: got hit=%b, want 0", hit);
    end
    @(posedge CLK);
    #1 upd_en = 1'b0;
    n_cmp++;
    if ({hit, predict_taken, target} !== {1'b1, 1'b1, 30'h40}) begin
      n_bad++;
      $display("FAIL hazard_next_cycle: got hit=%b pt=%b tgt=%h, want 1/1/40", hit, predict_taken, target);
    end
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({hit, predict_taken, target} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got hit=%b pt=%b tgt=%h, want 0/0/0", hit, predict_taken, target);
    end
    @(negedge CLK); nRST = 1'b1;
    look(30'h12);
    n_cmp++;
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: got hit=%b, want 0", hit);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_conflict();
    test_flush();
    test_hazard_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It sits beside the fetch stage and gives a same-cycle hit, taken prediction and target for the current fetch word address. It is trained by the execute stage with resolved branch outcomes. It replaces the fixed 4-entry, hit-only target buffer and adds configurable depth, direction prediction, a train-on-taken allocation policy and a global flush.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two, at least 2.
- PC_W, 30, word-address width (PC[31:2]).
- IDX_W, $clog2(ENTRIES), derived index width. TAG_W = PC_W - IDX_W, derived tag width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- lookup_pc  input  PC_W  fetch word address.
- hit  output  1  a valid entry matches lookup_pc.
- predict_taken  output  1  hit and the counter predicts taken.
- target  output  PC_W  predicted target word address.
- upd_en  input  1  resolved branch update strobe, one update per cycle.
- upd_pc  input  PC_W  word address of the resolved branch.
- upd_taken  input  1  resolved direction.
- upd_target  input  PC_W  resolved target word address.
- flush  input  1  invalidate all entries.

## Operation
- Per entry: valid (1), tag (TAG_W), target (PC_W), ctr (2).
- Address split: index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W]. The same split applies to lookup_pc and upd_pc.
- Lookup is purely combinational from the stored state:
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - predict_taken = hit & ctr[idx][1].
  - target = entry target when hit, otherwise all zeros.
- Update when upd_en=1 and flush=0. Let u = entry at the upd_pc index, and u_hit = u.valid & tag match.
  - u_hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - u_hit, not taken: ctr = max(ctr-1, 0); target unchanged. The entry stays valid at ctr=0 (it predicts not-taken).
  - miss, taken: allocate. valid=1, tag=upd tag, target=upd_target, ctr=2'b10 (weakly taken). This replaces any conflicting valid entry.
  - miss, not taken: no state change.
- Counter arithmetic is 2-bit saturating and never wraps: 3+1 stays 3, 0-1 stays 0.
- flush=1: every valid bit clears at the next edge. Tag, target and ctr are left as-is and are unobservable because hit=0. flush has priority over a same-cycle upd_en, and that update is dropped.
- Only the indexed entry changes on an update; all other entries hold.

## Timing
- Reset (nRST low, asynchronous): all valid=0, tag=0, target=0, ctr=0.
  - Outputs during and after reset: hit=0, predict_taken=0, target=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock.
- Lookup latency is 0 cycles: outputs follow lookup_pc and the current state combinationally.
- Update latency is 1 cycle: the effect is visible on lookup outputs in the cycle after the edge that samples upd_en.
- Same-cycle lookup and update to the same index: there is no bypass. The lookup returns the pre-update state.
- Back-to-back updates to the same entry on consecutive cycles each apply in order. Each update sees the result of the previous one.
- flush latency is 1 cycle: hit=0 for every address from the cycle after the flush edge.

## Test plan
1. Reset, then sweep lookup_pc over 0..15 -> hit=0, predict_taken=0, target=0 for every address.
2. Update pc=0x0000045, taken, target=0x0000100; next cycle look up 0x0000045 -> hit=1, predict_taken=1, target=0x0000100. Look up 0x0000055 (same index 5, different tag) -> hit=0, target=0.
3. Counter saturation on pc=0x0000045 after allocation (ctr=2):
   - Three taken updates -> ctr stays 3, predict_taken=1.
   - Then three not-taken updates -> ctr 2, 1, 0. predict_taken goes 0 once ctr reaches 1; hit stays 1.
   - A fourth not-taken update -> ctr stays 0, still hit.
4. Conflict replacement: with 0x0000045 valid, update pc=0x0000075 not-taken -> no change. Then update 0x0000075 taken, target=0x0000200 -> lookup 0x0000045 hit=0; lookup 0x0000075 hit=1, target=0x0000200, ctr=2.
5. Fill entries 0..15 with taken updates, then assert flush and upd_en together (taken, pc=0x0000003) in one cycle -> the next cycle every lookup returns hit=0, including 0x0000003.
6. Same-cycle hazard: lookup_pc=0x0000012 while allocating 0x0000012 -> hit=0 that cycle and hit=1 the next. Also assert nRST low between clock edges while entries are valid -> hit drops to 0 immediately.
